// File: rtl/fp16_pkg.sv
// Shared constants and FSM state type for the FP16 multiplier back end
// (normalise + round-to-nearest-even).
package fp16_pkg;

  localparam int          BIAS    = 15;
  localparam int          EXP_MAX = 31;
  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] PINF    = 16'h7C00;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/fp16_round_rne.sv
// Round-to-nearest-even increment of an 11-bit significand from its guard,
// round and sticky bits; carry flags overflow to 2^11.
module fp16_round_rne (
  input  logic [10:0] sig,
  input  logic        g,
  input  logic        r,
  input  logic        s,
  output logic [10:0] rounded_sig,
  output logic        carry
);

  logic inc;

  // Ties go to the even significand, hence the lsb term.
  assign inc = g & (r | s | sig[0]);
  assign {carry, rounded_sig} = {1'b0, sig} + {11'b0, inc};

endmodule

// File: rtl/fp16_norm_round.sv
// Normalises a raw 11x11 significand product and rounds it to binary16 (RNE),
// with a four-state IDLE/NORM/ROUND/DONE handshake FSM.
module fp16_norm_round
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [5:0]  in_exp_sum,
  input  logic [21:0] in_mant,
  input  logic        in_nan,
  input  logic        in_inf,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [2:0]  out_flags
);

  localparam logic signed [7:0] EXP_MAX_S = 8'(EXP_MAX);

  state_t state;

  logic        cap_sign;
  logic [5:0]  cap_exp_sum;
  logic [21:0] cap_mant;
  logic        cap_nan;
  logic        cap_inf;
  logic        cap_zero;

  logic [10:0]       sig_q;
  logic              g_q;
  logic              r_q;
  logic              s_q;
  logic signed [7:0] e_q;

  logic [10:0]       norm_sig;
  logic              norm_g;
  logic              norm_r;
  logic              norm_s;
  logic signed [7:0] norm_e;

  logic [10:0]       rounded_sig;
  logic              carry;
  logic [9:0]        final_frac;
  logic signed [7:0] final_e;
  logic [15:0]       res;
  logic [2:0]        res_flags;

  // Product lies in [1,4): a set bit 21 means one extra position of shift and +1 on e.
  always_comb begin
    norm_sig = cap_mant[20:10];
    norm_g   = cap_mant[9];
    norm_r   = cap_mant[8];
    norm_s   = |cap_mant[7:0];
    if (cap_mant[21]) begin
      norm_sig = cap_mant[21:11];
      norm_g   = cap_mant[10];
      norm_r   = cap_mant[9];
      norm_s   = |cap_mant[8:0];
    end
    norm_e = {2'b00, cap_exp_sum} - 8'(BIAS) + {7'b0, cap_mant[21]};
  end

  fp16_round_rne u_round (
    .sig         (sig_q),
    .g           (g_q),
    .r           (r_q),
    .s           (s_q),
    .rounded_sig (rounded_sig),
    .carry       (carry)
  );

  // A rounding carry means the significand became 2^11: shift right, bump e.
  assign final_frac = carry ? rounded_sig[10:1] : rounded_sig[9:0];
  assign final_e    = e_q + {7'b0, carry};

  always_comb begin
    res       = {cap_sign, final_e[4:0], final_frac};
    res_flags = {2'b00, g_q | r_q | s_q};
    if (cap_nan) begin
      res       = QNAN;
      res_flags = 3'b000;
    end else if (cap_inf) begin
      res       = {cap_sign, PINF[14:0]};
      res_flags = 3'b000;
    end else if (cap_zero) begin
      res       = {cap_sign, 15'h0};
      res_flags = 3'b000;
    end else if (final_e >= EXP_MAX_S) begin
      res       = {cap_sign, PINF[14:0]};
      res_flags = 3'b101;
    end else if (final_e <= 8'sd0) begin
      res       = {cap_sign, 15'h0};
      res_flags = 3'b011;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_result  <= 16'h0000;
      out_flags   <= 3'b000;
      cap_sign    <= 1'b0;
      cap_exp_sum <= '0;
      cap_mant    <= '0;
      cap_nan     <= 1'b0;
      cap_inf     <= 1'b0;
      cap_zero    <= 1'b0;
      sig_q       <= '0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      s_q         <= 1'b0;
      e_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap_sign    <= in_sign;
            cap_exp_sum <= in_exp_sum;
            cap_mant    <= in_mant;
            cap_nan     <= in_nan;
            cap_inf     <= in_inf;
            cap_zero    <= in_zero;
            in_ready    <= 1'b0;
            state       <= NORM;
          end
        end
        NORM: begin
          sig_q <= norm_sig;
          g_q   <= norm_g;
          r_q   <= norm_r;
          s_q   <= norm_s;
          e_q   <= norm_e;
          state <= ROUND;
        end
        ROUND: begin
          out_result <= res;
          out_flags  <= res_flags;
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
